regfile_ctrl: RTL

REGFILE_CTRL -- requirements
Module: regfile_ctrl

---
 rtl/regfile_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_ctrl.sv
// Sequencer that loads r basis vectors into an external register file and then emits NS
// LFSR-selected XOR combinations of them; define REJECT_ZERO_EN to skip all-zero selections.
module regfile_ctrl #(
   parameter int unsigned m  = 79,
   parameter int unsigned r  = 5,
   parameter int unsigned NS = 8
) (
   input  logic                                   clk,
   input  logic                                   rst_b,
   input  logic                                   start,
   input  logic [15:0]                            seed,
   input  logic                                   load_valid,
   input  logic [m-1:0]                           load_data,
   output logic                                   load_ready,
   output logic                                   rf_rw,
   output logic [r:0]                             rf_ctrl_w,
   output logic [((r > 1) ? $clog2(r) : 1)-1:0]   rf_addr,
   output logic [m-1:0]                           rf_data_in,
   input  logic [m-1:0]                           rf_data_out,
   output logic                                   out_valid,
   output logic [m-1:0]                           out_data,
   input  logic                                   out_ready,
   output logic                                   busy,
   output logic                                   done
);

   localparam int unsigned AW = (r > 1) ? $clog2(r) : 1;
   localparam int unsigned CW = $clog2(NS + 1);
   localparam logic [15:0] LFSR_INIT = 16'hACE1;

   typedef enum logic [2:0] {IDLE, LOAD, GEN, CAP, HOLD, DONE} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [AW-1:0]  idx;
   logic [CW-1:0]  cnt;
   logic [15:0]    lfsr;
   logic           load_fire;
   logic           combo_zero;
   logic           gen_issue;
   logic           lfsr_fb;

   assign load_fire  = (state == LOAD) && load_valid;
   assign combo_zero = (lfsr[r-1:0] == '0);
   assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

`ifdef REJECT_ZERO_EN
   assign gen_issue  = (state == GEN) && !combo_zero;
`else
   assign gen_issue  = (state == GEN);
`endif

   // State register
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = LOAD;
         LOAD: if (load_fire && (idx == AW'(r - 1))) state_nxt = GEN;
         GEN:  if (gen_issue) state_nxt = CAP;
         CAP:  state_nxt = HOLD;
         HOLD: if (out_ready) state_nxt = (cnt == CW'(NS - 1)) ? DONE : GEN;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Decoded outputs; load beats pass straight through to the register-file port
   always_comb begin
      load_ready = 1'b0;
      rf_rw      = 1'b0;
      rf_ctrl_w  = '0;
      rf_addr    = '0;
      rf_data_in = '0;
      busy       = (state != IDLE);
      done       = (state == DONE);
      case (state)
         LOAD: begin
            load_ready = 1'b1;
            if (load_valid) begin
               rf_rw      = 1'b1;
               rf_addr    = idx;
               rf_data_in = load_data;
            end
         end
         GEN: if (gen_issue) rf_ctrl_w = {1'b1, lfsr[r-1:0]};
         default: ;
      endcase
   end

   // Load index, sample count and LFSR
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         idx  <= '0;
         cnt  <= '0;
         lfsr <= LFSR_INIT;
      end else begin
         if (state == IDLE && start) begin
            idx  <= '0;
            cnt  <= '0;
            lfsr <= (seed == 16'h0000) ? LFSR_INIT : seed;
         end
         if (load_fire) idx <= AW'(idx + 1'b1);
         if (state == GEN) lfsr <= {lfsr[14:0], lfsr_fb};
         if (state == HOLD && out_ready) cnt <= CW'(cnt + 1'b1);
      end
   end

   // Sample register: rf_data_out is only meaningful the cycle after an issued combination
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (state == CAP) begin
         out_valid <= 1'b1;
         out_data  <= rf_data_out;
      end else if (state == HOLD && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
